// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory-stage access controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

    localparam logic [47:0] DEFAULT_ERR_DATA = 48'hDEAD;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned chIdxWidth(input int unsigned nCh);
        return (nCh > 1) ? $clog2(nCh) : 1;
    endfunction

endpackage

// File: rtl/mem_ch_mux.sv
// N_CH:1 read-data mux with one-hot request decode and a range check on the selected channel.
module mem_ch_mux #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 48,
    parameter int unsigned IDX_W  = 2
) (
    input  logic [IDX_W-1:0]       sel,
    input  logic [N_CH*DATA_W-1:0] chRdata,
    output logic [N_CH-1:0]        oneHot,
    output logic [DATA_W-1:0]      rdata,
    output logic                   legal
);

    localparam int unsigned EXT_W = IDX_W + 1;
    localparam logic [EXT_W-1:0] N_CH_EXT = EXT_W'(N_CH);

    // Extra bit keeps the compare correct when N_CH is a power of two.
    assign legal = {1'b0, sel} < N_CH_EXT;

    always_comb begin
        oneHot = '0;
        rdata  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == IDX_W'(i)) begin
                oneHot[i] = 1'b1;
                rdata     = chRdata[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: steers one load/store to a channel and stalls the pipeline
// while a handshaked channel is outstanding, with timeout and sticky error reporting.
module mem_stage_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned      DATA_W    = 48,
    parameter int unsigned      ADDR_W    = 48,
    parameter int unsigned      N_CH      = 4,
    parameter logic [N_CH-1:0]  FAST_MASK = N_CH'(1),
    parameter int unsigned      TIMEOUT   = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEFAULT_ERR_DATA)
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic                          REQ_VALID,
    input  logic                          REQ_WE,
    input  logic [chIdxWidth(N_CH)-1:0]   REQ_CH,
    input  logic [ADDR_W-1:0]             REQ_ADDR,
    input  logic [DATA_W-1:0]             REQ_WDATA,
    output logic                          STALL,
    output logic                          RSP_VALID,
    output logic [DATA_W-1:0]             RSP_RDATA,
    output logic [N_CH-1:0]               CH_REQ,
    output logic                          CH_WE,
    output logic [ADDR_W-1:0]             CH_ADDR,
    output logic [DATA_W-1:0]             CH_WDATA,
    input  logic [N_CH-1:0]               CH_ACK,
    input  logic [N_CH*DATA_W-1:0]        CH_RDATA,
    input  logic                          ERR_CLR,
    output logic                          ERR
);

    localparam int unsigned IDX_W = chIdxWidth(N_CH);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    mem_state_t        stateQ, stateD;
    logic [IDX_W-1:0]  chQ, chD;
    logic [CNT_W-1:0]  cntQ, cntD;
    logic [DATA_W-1:0] holdQ, holdD;
    logic              errQ, errD, errSet;

    logic [IDX_W-1:0]  muxSel;
    logic [N_CH-1:0]   selOneHot;
    logic [DATA_W-1:0] selRdata;
    logic              selLegal, selFast, selAck;

    // While waiting, the latched channel drives the mux; otherwise the live request does.
    assign muxSel = (stateQ == WAIT) ? chQ : REQ_CH;

    mem_ch_mux #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) uChMux (
        .sel     (muxSel),
        .chRdata (CH_RDATA),
        .oneHot  (selOneHot),
        .rdata   (selRdata),
        .legal   (selLegal)
    );

    assign selFast = |(selOneHot & FAST_MASK);
    assign selAck  = |(selOneHot & CH_ACK);

    assign CH_WE    = REQ_WE;
    assign CH_ADDR  = REQ_ADDR;
    assign CH_WDATA = REQ_WDATA;
    assign ERR      = errQ;

    always_comb begin
        stateD    = stateQ;
        chD       = chQ;
        cntD      = cntQ;
        holdD     = holdQ;
        errSet    = 1'b0;
        STALL     = 1'b0;
        RSP_VALID = 1'b0;
        RSP_RDATA = '0;
        CH_REQ    = '0;
        // Combinational outputs also read as reset values while Reset is held low.
        if (Reset) begin
            unique case (stateQ)
                IDLE: begin
                    if (REQ_VALID) begin
                        if (!selLegal) begin
                            RSP_VALID = 1'b1;
                            RSP_RDATA = ERR_DATA;
                            errSet    = 1'b1;
                        end else if (selFast) begin
                            CH_REQ    = selOneHot;
                            RSP_VALID = 1'b1;
                            RSP_RDATA = selRdata;
                        end else begin
                            CH_REQ = selOneHot;
                            STALL  = 1'b1;
                            chD    = REQ_CH;
                            cntD   = CNT_W'(1);
                            stateD = WAIT;
                        end
                    end
                end
                WAIT: begin
                    CH_REQ = selOneHot;
                    STALL  = 1'b1;
                    if (selAck) begin
                        holdD  = selRdata;
                        stateD = DONE;
                    end else if (cntQ >= CNT_LIMIT) begin
                        holdD  = ERR_DATA;
                        errSet = 1'b1;
                        stateD = DONE;
                    end else if (cntQ != '1) begin
                        cntD = cntQ + CNT_W'(1);
                    end
                end
                DONE: begin
                    RSP_VALID = 1'b1;
                    RSP_RDATA = holdQ;
                    cntD      = '0;
                    stateD    = IDLE;
                end
                default: stateD = IDLE;
            endcase
        end
    end

    // A new error wins over a simultaneous clear.
    always_comb begin
        errD = errQ;
        if (errSet) begin
            errD = 1'b1;
        end else if (ERR_CLR) begin
            errD = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            stateQ <= IDLE;
            chQ    <= '0;
            cntQ   <= '0;
            holdQ  <= '0;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            chQ    <= chD;
            cntQ   <= cntD;
            holdQ  <= holdD;
            errQ   <= errD;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: vector table for single-cycle cases, hand sequences
// for stalls, timeout, reset abort and back-to-back access, with a response scoreboard.
module tb_mem_stage_ctrl;

    localparam int unsigned DW  = 48;
    localparam int unsigned AW  = 48;
    localparam int unsigned NCH = 3;
    localparam int unsigned TO  = 8;
    localparam logic [DW-1:0] ERRD = 48'hDEAD;

    logic              CLK = 1'b0;
    logic              Reset;
    logic              REQ_VALID, REQ_WE;
    logic [1:0]        REQ_CH;
    logic [AW-1:0]     REQ_ADDR;
    logic [DW-1:0]     REQ_WDATA;
    logic              STALL, RSP_VALID;
    logic [DW-1:0]     RSP_RDATA;
    logic [NCH-1:0]    CH_REQ;
    logic              CH_WE;
    logic [AW-1:0]     CH_ADDR;
    logic [DW-1:0]     CH_WDATA;
    logic [NCH-1:0]    CH_ACK;
    logic [NCH*DW-1:0] CH_RDATA;
    logic              ERR_CLR, ERR;

    int nCompared   = 0;
    int nMismatched = 0;
    logic [DW-1:0] sb[$];

    always #5 CLK = ~CLK;

    mem_stage_ctrl #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .N_CH      (NCH),
        .FAST_MASK (3'b001),
        .TIMEOUT   (TO),
        .ERR_DATA  (ERRD)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .REQ_VALID (REQ_VALID),
        .REQ_WE    (REQ_WE),
        .REQ_CH    (REQ_CH),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .STALL     (STALL),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .CH_REQ    (CH_REQ),
        .CH_WE     (CH_WE),
        .CH_ADDR   (CH_ADDR),
        .CH_WDATA  (CH_WDATA),
        .CH_ACK    (CH_ACK),
        .CH_RDATA  (CH_RDATA),
        .ERR_CLR   (ERR_CLR),
        .ERR       (ERR)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [NCH-1:0] oneHot(input logic [1:0] c);
        logic [NCH-1:0] r;
        r = NCH'(1) << c;
        return r;
    endfunction

    // Scoreboard: every response the DUT presents is matched against the oldest expectation.
    always @(negedge CLK) begin
        if (Reset === 1'b1 && RSP_VALID === 1'b1) begin
            if (sb.size() == 0) begin
                check("rsp without request", {63'd0, RSP_VALID}, 64'd0);
            end else begin
                check("rsp data", {16'd0, RSP_RDATA}, {16'd0, sb.pop_front()});
            end
        end
    end

    task automatic runSlow(input string name, input logic [1:0] ch, input int ackAt,
                           input logic [NCH-1:0] noise, input logic [DW-1:0] data,
                           input logic [DW-1:0] expData, input int expStalls);
        int stalls = 0;
        int reqs   = 0;
        int cyc    = 0;
        bit done   = 1'b0;
        logic [NCH-1:0] sel;
        sel       = oneHot(ch);
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b0;
        REQ_CH    = ch;
        REQ_ADDR  = 48'h1000 + AW'(ch);
        REQ_WDATA = '0;
        CH_RDATA[int'(ch)*DW +: DW] = data;
        sb.push_back(expData);
        while (!done && cyc < 40) begin
            CH_ACK = ((ackAt != 0 && cyc == ackAt) ? sel : '0) | (noise & ~sel);
            @(negedge CLK);
            if (RSP_VALID === 1'b1) begin
                done = 1'b1;
                check({name, " done stall"}, {63'd0, STALL}, 64'd0);
                check({name, " done chreq"}, {61'd0, CH_REQ}, 64'd0);
            end else begin
                if (STALL === 1'b1) stalls++;
                if (CH_REQ === sel) reqs++;
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        CH_ACK    = '0;
        REQ_VALID = 1'b0;
        check({name, " completed"}, {63'd0, done}, 64'd1);
        check({name, " stall cycles"}, 64'(stalls), 64'(expStalls));
        check({name, " chreq cycles"}, 64'(reqs), 64'(expStalls));
    endtask

    typedef struct {
        logic           valid;
        logic           we;
        logic [1:0]     ch;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [DW-1:0]  rd0;
        logic [NCH-1:0] ack;
        logic           expRv;
        logic [DW-1:0]  expRd;
        logic [NCH-1:0] expReq;
        logic           expErr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 2'd0, 48'h10,  48'h0,    48'h123,          3'b000,
                    1'b0, 48'h0,            3'b000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 2'd0, 48'h100, 48'h0,    48'h123,          3'b000,
                    1'b1, 48'h123,          3'b001, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 2'd0, 48'h104, 48'h555,  48'h0,            3'b000,
                    1'b1, 48'h0,            3'b001, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 2'd0, 48'h108, 48'h0,    48'hFFFFFFFFFFFF, 3'b110,
                    1'b1, 48'hFFFFFFFFFFFF, 3'b001, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 2'd2, 48'h10C, 48'h0,    48'h77,           3'b000,
                    1'b0, 48'h0,            3'b000, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 2'd3, 48'h110, 48'h0,    48'h77,           3'b000,
                    1'b1, ERRD,             3'b000, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 2'd0, 48'h114, 48'hBEEF, 48'h42,           3'b000,
                    1'b1, 48'h42,           3'b001, 1'b1};

        REQ_VALID = 1'b0;
        REQ_WE    = 1'b0;
        REQ_CH    = '0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        CH_ACK    = '0;
        CH_RDATA  = {48'h222, 48'h111, 48'h0};
        ERR_CLR   = 1'b0;
        Reset     = 1'b1;
        #1 Reset  = 1'b0;
        #2;
        check("reset stall", {63'd0, STALL}, 64'd0);
        check("reset rsp_valid", {63'd0, RSP_VALID}, 64'd0);
        check("reset rsp_rdata", {16'd0, RSP_RDATA}, 64'd0);
        check("reset chreq", {61'd0, CH_REQ}, 64'd0);
        check("reset err", {63'd0, ERR}, 64'd0);
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        #1;

        // Single-cycle cases from IDLE.
        foreach (vecs[i]) begin
            REQ_VALID = vecs[i].valid;
            REQ_WE    = vecs[i].we;
            REQ_CH    = vecs[i].ch;
            REQ_ADDR  = vecs[i].addr;
            REQ_WDATA = vecs[i].wdata;
            CH_RDATA[0 +: DW] = vecs[i].rd0;
            CH_ACK    = vecs[i].ack;
            if (vecs[i].expRv) sb.push_back(vecs[i].expRd);
            @(negedge CLK);
            check($sformatf("vec%0d stall", i), {63'd0, STALL}, 64'd0);
            check($sformatf("vec%0d rsp_valid", i), {63'd0, RSP_VALID}, {63'd0, vecs[i].expRv});
            check($sformatf("vec%0d chreq", i), {61'd0, CH_REQ}, {61'd0, vecs[i].expReq});
            check($sformatf("vec%0d ch_we", i), {63'd0, CH_WE}, {63'd0, vecs[i].we});
            check($sformatf("vec%0d ch_addr", i), {16'd0, CH_ADDR}, {16'd0, vecs[i].addr});
            check($sformatf("vec%0d ch_wdata", i), {16'd0, CH_WDATA}, {16'd0, vecs[i].wdata});
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d err", i), {63'd0, ERR}, {63'd0, vecs[i].expErr});
        end
        REQ_VALID = 1'b0;
        CH_ACK    = '0;
        ERR_CLR   = 1'b1;
        @(posedge CLK);
        #1;
        ERR_CLR = 1'b0;
        check("err cleared", {63'd0, ERR}, 64'd0);

        // Slow channel, ACK in the third wait cycle, stray ACKs on other channels.
        runSlow("slow ch1", 2'd1, 3, 3'b101, 48'hABC, 48'hABC, 4);
        check("slow ch1 err", {63'd0, ERR}, 64'd0);

        // No ACK at all: timeout returns error data and sets the sticky flag.
        runSlow("timeout ch2", 2'd2, 0, 3'b000, 48'h777, ERRD, TO + 1);
        check("timeout err", {63'd0, ERR}, 64'd1);
        repeat (2) @(posedge CLK);
        #1;
        check("timeout err sticky", {63'd0, ERR}, 64'd1);
        ERR_CLR = 1'b1;
        @(posedge CLK);
        #1;
        ERR_CLR = 1'b0;
        check("timeout err clear", {63'd0, ERR}, 64'd0);

        // ACK on the very cycle the counter reaches the limit: data wins.
        runSlow("ack at limit", 2'd2, TO, 3'b000, 48'h4444, 48'h4444, TO + 1);
        check("ack at limit err", {63'd0, ERR}, 64'd0);

        // Error set and clear together: set wins.
        REQ_VALID = 1'b1;
        REQ_CH    = 2'd3;
        ERR_CLR   = 1'b1;
        sb.push_back(ERRD);
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        ERR_CLR   = 1'b0;
        check("set beats clear", {63'd0, ERR}, 64'd1);

        // Reset in the middle of a wait abandons the access.
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b0;
        REQ_CH    = 2'd1;
        repeat (3) @(posedge CLK);
        #1;
        check("pre-reset stall", {63'd0, STALL}, 64'd1);
        Reset = 1'b0;
        #1;
        check("mid reset stall", {63'd0, STALL}, 64'd0);
        check("mid reset rsp_valid", {63'd0, RSP_VALID}, 64'd0);
        check("mid reset rsp_rdata", {16'd0, RSP_RDATA}, 64'd0);
        check("mid reset chreq", {61'd0, CH_REQ}, 64'd0);
        check("mid reset err", {63'd0, ERR}, 64'd0);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        CH_ACK = 3'b010;
        @(negedge CLK);
        check("late ack stall", {63'd0, STALL}, 64'd0);
        check("late ack rsp_valid", {63'd0, RSP_VALID}, 64'd0);
        check("late ack chreq", {61'd0, CH_REQ}, 64'd0);
        @(posedge CLK);
        #1;
        CH_ACK = '0;
        runSlow("min slow ch1", 2'd1, 1, 3'b000, 48'h5151, 48'h5151, 2);

        // Slow load straight into a fast store: store issues once, slow channel not re-requested.
        runSlow("b2b slow ch2", 2'd2, 2, 3'b000, 48'h2222, 48'h2222, 3);
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b1;
        REQ_CH    = 2'd0;
        REQ_WDATA = 48'h5A5A;
        CH_RDATA[0 +: DW] = 48'h9;
        sb.push_back(48'h9);
        @(negedge CLK);
        check("b2b store chreq", {61'd0, CH_REQ}, 64'b001);
        check("b2b store stall", {63'd0, STALL}, 64'd0);
        check("b2b store ch_we", {63'd0, CH_WE}, 64'd1);
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check("b2b no reissue", {61'd0, CH_REQ}, 64'd0);
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b0;
        REQ_CH    = 2'd3;
        sb.push_back(ERRD);
        @(negedge CLK);
        check("illegal stall", {63'd0, STALL}, 64'd0);
        check("illegal chreq", {61'd0, CH_REQ}, 64'd0);
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        check("illegal err", {63'd0, ERR}, 64'd1);
        @(posedge CLK);
        #1;
        check("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
